// File: rtl/gmp_channel_packer_pkg.sv
// Shared defaults, state encoding and slot addressing for the GMP channel packer.
package gmp_channel_packer_pkg;

    localparam int unsigned GMP_BIT_SIZE        = 8;
    localparam int unsigned GMP_ACTIVATIONS     = 36;
    localparam int unsigned GMP_NUM_CHANNELS    = 10;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } gmp_state_e;

    function automatic int unsigned slot_offset(input int unsigned j, input int unsigned bits);
        return j * bits;
    endfunction

endpackage

// File: rtl/gmp_channel_packer_if.sv
// Pixel-in / packed-channel-out stream bundle for gmp_channel_packer.
// out_max exists only when GMP_PACK_RUNMAX_EN is defined.
interface gmp_channel_packer_if
    import gmp_channel_packer_pkg::*;
#(
    parameter int unsigned BIT_SIZE        = GMP_BIT_SIZE,
    parameter int unsigned ACTIVATIONS_GMP = GMP_ACTIVATIONS,
    parameter int unsigned NUM_CHANNELS    = GMP_NUM_CHANNELS,
    parameter int unsigned CH_W            = $clog2(NUM_CHANNELS)
);

    logic                                 in_valid;
    logic                                 in_ready;
    logic signed [BIT_SIZE-1:0]           in_pixel;
    logic                                 in_last;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [BIT_SIZE*ACTIVATIONS_GMP-1:0]  out_bus;
    logic [CH_W-1:0]                      out_channel;
    logic                                 err_len;
`ifdef GMP_PACK_RUNMAX_EN
    logic signed [BIT_SIZE-1:0]           out_max;
`endif

    modport master (
        output in_valid, in_pixel, in_last, out_ready,
        input  in_ready, out_valid, out_bus, out_channel, err_len
`ifdef GMP_PACK_RUNMAX_EN
        , input out_max
`endif
    );

    modport slave (
        input  in_valid, in_pixel, in_last, out_ready,
        output in_ready, out_valid, out_bus, out_channel, err_len
`ifdef GMP_PACK_RUNMAX_EN
        , output out_max
`endif
    );

endinterface

// File: rtl/gmp_channel_packer_ctrl.sv
// FILL/HOLD sequencer for the packer: slot counter, channel index, sticky length error,
// and the slot write / bus clear strobes consumed by the top-level data registers.
module gmp_pack_ctrl
    import gmp_channel_packer_pkg::*;
#(
    parameter int unsigned ACTIVATIONS_GMP = GMP_ACTIVATIONS,
    parameter int unsigned NUM_CHANNELS    = GMP_NUM_CHANNELS,
    parameter int unsigned CH_W            = $clog2(NUM_CHANNELS),
    parameter int unsigned CNT_W           = $clog2(ACTIVATIONS_GMP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_channel,
    output logic             err_len,
    output logic             wr_en,
    output logic [CNT_W-1:0] wr_slot,
    output logic             bus_clr
);

    gmp_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CH_W-1:0]  channel_q, channel_d;
    logic             err_q, err_d;
    logic             at_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FILL;
            count_q   <= '0;
            channel_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            channel_q <= channel_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        channel_d = channel_q;
        err_d     = err_q;
        wr_en     = 1'b0;
        bus_clr   = 1'b0;
        at_end    = (count_q == CNT_W'(ACTIVATIONS_GMP - 1));

        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (at_end || in_last) begin
                        state_d = HOLD;
                    end
                    // Either a premature in_last or a full slot set without in_last is a length error.
                    if (at_end != in_last) begin
                        err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d   = FILL;
                    count_d   = '0;
                    bus_clr   = 1'b1;
                    channel_d = (channel_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : channel_q + CH_W'(1);
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign in_ready    = (state_q == FILL);
    assign out_valid   = (state_q == HOLD);
    assign out_channel = channel_q;
    assign err_len     = err_q;
    assign wr_slot     = count_q;

endmodule

// File: rtl/gmp_channel_packer.sv
// Packs ACTIVATIONS_GMP pixels per channel into one flat bus for global max-pool.
// Optional GMP_PACK_RUNMAX_EN adds a signed running max (0 floor) on out_max.
module gmp_channel_packer
    import gmp_channel_packer_pkg::*;
#(
    parameter int unsigned BIT_SIZE        = GMP_BIT_SIZE,
    parameter int unsigned ACTIVATIONS_GMP = GMP_ACTIVATIONS,
    parameter int unsigned NUM_CHANNELS    = GMP_NUM_CHANNELS,
    parameter int unsigned CH_W            = $clog2(NUM_CHANNELS)
) (
    input  logic                 clk,
    input  logic                 rst,
    gmp_channel_packer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(ACTIVATIONS_GMP);

    logic                                wr_en;
    logic                                bus_clr;
    logic [CNT_W-1:0]                    wr_slot;
    logic                                in_ready;
    logic                                out_valid;
    logic [CH_W-1:0]                     out_channel;
    logic                                err_len;
    logic [BIT_SIZE-1:0]                 slot_q [ACTIVATIONS_GMP];
    logic [BIT_SIZE-1:0]                 slot_d [ACTIVATIONS_GMP];
    logic [BIT_SIZE*ACTIVATIONS_GMP-1:0] packed_bus;

    gmp_pack_ctrl #(
        .ACTIVATIONS_GMP (ACTIVATIONS_GMP),
        .NUM_CHANNELS    (NUM_CHANNELS),
        .CH_W            (CH_W),
        .CNT_W           (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (bus.in_valid),
        .in_last     (bus.in_last),
        .out_ready   (bus.out_ready),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_channel (out_channel),
        .err_len     (err_len),
        .wr_en       (wr_en),
        .wr_slot     (wr_slot),
        .bus_clr     (bus_clr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q <= '{default: '0};
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        slot_d = slot_q;
        if (bus_clr) begin
            slot_d = '{default: '0};
        end else if (wr_en) begin
            slot_d[wr_slot] = bus.in_pixel;
        end
    end

    always_comb begin
        packed_bus = '0;
        for (int unsigned j = 0; j < ACTIVATIONS_GMP; j++) begin
            packed_bus[slot_offset(j, BIT_SIZE) +: BIT_SIZE] = slot_q[j];
        end
    end

`ifdef GMP_PACK_RUNMAX_EN
    logic signed [BIT_SIZE-1:0] max_q, max_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    // Starting from 0 gives the max-pool floor for all-negative channels.
    always_comb begin
        max_d = max_q;
        if (bus_clr) begin
            max_d = '0;
        end else if (wr_en && (bus.in_pixel > max_q)) begin
            max_d = bus.in_pixel;
        end
    end

    assign bus.out_max = max_q;
`endif

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_channel = out_channel;
    assign bus.err_len     = err_len;
    assign bus.out_bus     = packed_bus;

endmodule

// File: tb/tb_gmp_channel_packer.sv
// Directed self-checking bench for gmp_channel_packer (default and GMP_PACK_RUNMAX_EN builds).
module tb_gmp_channel_packer;

    localparam int unsigned BS = 8;
    localparam int unsigned NA = 36;
    localparam int unsigned NC = 10;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gmp_channel_packer_if #(
        .BIT_SIZE        (BS),
        .ACTIVATIONS_GMP (NA),
        .NUM_CHANNELS    (NC),
        .CH_W            (CW)
    ) bus_if ();

    gmp_channel_packer #(
        .BIT_SIZE        (BS),
        .ACTIVATIONS_GMP (NA),
        .NUM_CHANNELS    (NC),
        .CH_W            (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [BS*NA-1:0] exp_bus;
    logic [BS-1:0]    slot_v;

    // Drives one pixel from posedge+1 and returns at posedge+1 after it was taken.
    task automatic push(input logic [BS-1:0] v, input logic last);
        int unsigned budget;
        bus_if.in_valid = 1'b1;
        bus_if.in_pixel = v;
        bus_if.in_last  = last;
        budget = 0;
        while (bus_if.in_ready !== 1'b1 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        n_cmp++;
        if (bus_if.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL push_wait: in_ready=%b required 1 within 50 cycles", bus_if.in_ready);
        end
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        bus_if.in_last  = 1'b0;
    endtask

    task automatic release_hold();
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus_if.in_valid  = 1'b0;
        bus_if.in_pixel  = '0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b0;
        #2 rst = 1'b0;
        #10;
        n_cmp++; if (bus_if.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus_if.in_ready); end
        n_cmp++; if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus_if.out_valid); end
        n_cmp++; if (bus_if.out_bus !== '0) begin n_err++; $display("FAIL rst_out_bus: got %h want 0", bus_if.out_bus); end
        n_cmp++; if (bus_if.out_channel !== 4'd0) begin n_err++; $display("FAIL rst_channel: got %0d want 0", bus_if.out_channel); end
        n_cmp++; if (bus_if.err_len !== 1'b0) begin n_err++; $display("FAIL rst_err_len: got %b want 0", bus_if.err_len); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // out_ready held high through the fill: it must be ignored until HOLD.
    task automatic test_full_channel();
        bus_if.out_ready = 1'b1;
        for (int j = 0; j < NA; j++) begin
            exp_bus[j*BS +: BS] = 8'(j + 1);
            push(8'(j + 1), j == NA - 1);
        end
        n_cmp++; if (bus_if.out_valid !== 1'b1) begin n_err++; $display("FAIL full_latency: out_valid=%b want 1", bus_if.out_valid); end
        n_cmp++; if (bus_if.in_ready !== 1'b0) begin n_err++; $display("FAIL full_hold_ready: in_ready=%b want 0", bus_if.in_ready); end
        slot_v = bus_if.out_bus[0 +: BS];
        n_cmp++; if (slot_v !== 8'd1) begin n_err++; $display("FAIL full_slot0: got %h want 01", slot_v); end
        slot_v = bus_if.out_bus[35*BS +: BS];
        n_cmp++; if (slot_v !== 8'd36) begin n_err++; $display("FAIL full_slot35: got %h want 24", slot_v); end
        n_cmp++; if (bus_if.out_bus !== exp_bus) begin n_err++; $display("FAIL full_bus: got %h want %h", bus_if.out_bus, exp_bus); end
        n_cmp++; if (bus_if.out_channel !== 4'd0) begin n_err++; $display("FAIL full_channel: got %0d want 0", bus_if.out_channel); end
        n_cmp++; if (bus_if.err_len !== 1'b0) begin n_err++; $display("FAIL full_err: got %b want 0", bus_if.err_len); end
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        n_cmp++; if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin n_err++; $display("FAIL full_back_to_fill: out_valid=%b in_ready=%b want 0/1", bus_if.out_valid, bus_if.in_ready); end
        n_cmp++; if (bus_if.out_bus !== '0) begin n_err++; $display("FAIL full_clear: got %h want 0", bus_if.out_bus); end
        n_cmp++; if (bus_if.out_channel !== 4'd1) begin n_err++; $display("FAIL full_next_channel: got %0d want 1", bus_if.out_channel); end
    endtask

    task automatic test_backpressure();
        for (int j = 0; j < NA; j++) begin
            exp_bus[j*BS +: BS] = 8'(j*3 + 2);
            push(8'(j*3 + 2), j == NA - 1);
        end
        bus_if.in_valid = 1'b1;
        bus_if.in_pixel = 8'h55;
        bus_if.in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus_if.out_bus !== exp_bus) begin n_err++; $display("FAIL bp_bus_stable[%0d]: got %h want %h", c, bus_if.out_bus, exp_bus); end
            n_cmp++; if (bus_if.in_ready !== 1'b0 || bus_if.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d]: in_ready=%b out_valid=%b want 0/1", c, bus_if.in_ready, bus_if.out_valid); end
        end
        n_cmp++; if (bus_if.out_channel !== 4'd1) begin n_err++; $display("FAIL bp_channel: got %0d want 1", bus_if.out_channel); end
        bus_if.in_valid = 1'b0;
        bus_if.in_last  = 1'b0;
        release_hold();
        n_cmp++; if (bus_if.out_bus !== '0) begin n_err++; $display("FAIL bp_clear: got %h want 0", bus_if.out_bus); end
        for (int j = 0; j < NA; j++) begin
            exp_bus[j*BS +: BS] = 8'(j) ^ 8'h5A;
            push(8'(j) ^ 8'h5A, j == NA - 1);
        end
        n_cmp++; if (bus_if.out_bus !== exp_bus) begin n_err++; $display("FAIL bp_next_from_slot0: got %h want %h", bus_if.out_bus, exp_bus); end
        n_cmp++; if (bus_if.err_len !== 1'b0) begin n_err++; $display("FAIL bp_err: got %b want 0", bus_if.err_len); end
        n_cmp++; if (bus_if.out_channel !== 4'd2) begin n_err++; $display("FAIL bp_next_channel: got %0d want 2", bus_if.out_channel); end
        release_hold();
    endtask

    task automatic test_early_last();
        n_cmp++; if (bus_if.err_len !== 1'b0) begin n_err++; $display("FAIL early_pre_err: got %b want 0", bus_if.err_len); end
        exp_bus = '0;
        for (int j = 0; j < 10; j++) begin
            exp_bus[j*BS +: BS] = 8'h7F;
            push(8'h7F, j == 9);
        end
        n_cmp++; if (bus_if.out_valid !== 1'b1) begin n_err++; $display("FAIL early_hold: out_valid=%b want 1", bus_if.out_valid); end
        n_cmp++; if (bus_if.out_bus !== exp_bus) begin n_err++; $display("FAIL early_bus: got %h want %h", bus_if.out_bus, exp_bus); end
        n_cmp++; if (bus_if.err_len !== 1'b1) begin n_err++; $display("FAIL early_err: got %b want 1", bus_if.err_len); end
        n_cmp++; if (bus_if.out_channel !== 4'd3) begin n_err++; $display("FAIL early_channel: got %0d want 3", bus_if.out_channel); end
        release_hold();
        for (int j = 0; j < NA; j++) begin
            exp_bus[j*BS +: BS] = 8'(8'h80 + j);
            push(8'(8'h80 + j), j == NA - 1);
        end
        n_cmp++; if (bus_if.out_bus !== exp_bus) begin n_err++; $display("FAIL early_clean_bus: got %h want %h", bus_if.out_bus, exp_bus); end
        n_cmp++; if (bus_if.err_len !== 1'b1) begin n_err++; $display("FAIL early_err_sticky: got %b want 1", bus_if.err_len); end
        release_hold();
    endtask

    task automatic test_missing_last();
        pulse_reset();
        n_cmp++; if (bus_if.err_len !== 1'b0 || bus_if.out_channel !== 4'd0) begin n_err++; $display("FAIL ml_reset: err=%b ch=%0d want 0/0", bus_if.err_len, bus_if.out_channel); end
        for (int j = 0; j < NA; j++) begin
            exp_bus[j*BS +: BS] = 8'(8'hC0 - j);
            push(8'(8'hC0 - j), 1'b0);
        end
        n_cmp++; if (bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0) begin n_err++; $display("FAIL ml_hold: out_valid=%b in_ready=%b want 1/0", bus_if.out_valid, bus_if.in_ready); end
        n_cmp++; if (bus_if.out_bus !== exp_bus) begin n_err++; $display("FAIL ml_bus: got %h want %h", bus_if.out_bus, exp_bus); end
        n_cmp++; if (bus_if.err_len !== 1'b1) begin n_err++; $display("FAIL ml_err: got %b want 1", bus_if.err_len); end
        release_hold();
        for (int j = 0; j < NA; j++) begin
            exp_bus[j*BS +: BS] = 8'(j + 9);
            push(8'(j + 9), j == NA - 1);
        end
        n_cmp++; if (bus_if.out_channel !== 4'd1) begin n_err++; $display("FAIL ml_next_channel: got %0d want 1", bus_if.out_channel); end
        n_cmp++; if (bus_if.out_bus !== exp_bus) begin n_err++; $display("FAIL ml_next_bus: got %h want %h", bus_if.out_bus, exp_bus); end
        release_hold();
    endtask

    task automatic test_channel_wrap();
        logic signed [BS-1:0] px;
        logic signed [BS-1:0] exp_max;
        pulse_reset();
        for (int c = 0; c <= NC; c++) begin
            exp_max = '0;
            for (int j = 0; j < NA; j++) begin
                if (c == 0)      px = (j == 17) ? 8'sd3 : -8'sd5;
                else if (c == 1) px = -8'sd5;
                else             px = 8'(c*13 + j*5);
                if (px > exp_max) exp_max = px;
                exp_bus[j*BS +: BS] = px;
                push(px, j == NA - 1);
            end
            n_cmp++; if (bus_if.out_channel !== 4'(c % NC)) begin n_err++; $display("FAIL wrap_channel[%0d]: got %0d want %0d", c, bus_if.out_channel, c % NC); end
            n_cmp++; if (bus_if.out_bus !== exp_bus) begin n_err++; $display("FAIL wrap_bus[%0d]: got %h want %h", c, bus_if.out_bus, exp_bus); end
`ifdef GMP_PACK_RUNMAX_EN
            n_cmp++; if (bus_if.out_max !== exp_max) begin n_err++; $display("FAIL wrap_max[%0d]: got %0d want %0d", c, bus_if.out_max, exp_max); end
`endif
            release_hold();
        end
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 19; j++) push(8'(j + 1), 1'b0);
        bus_if.in_valid = 1'b1;
        bus_if.in_pixel = 8'd20;
        #3 rst = 1'b0;
        #1;
        n_cmp++; if (bus_if.out_bus !== '0) begin n_err++; $display("FAIL rmid_bus: got %h want 0", bus_if.out_bus); end
        n_cmp++; if (bus_if.out_channel !== 4'd0) begin n_err++; $display("FAIL rmid_channel: got %0d want 0", bus_if.out_channel); end
        n_cmp++; if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1 || bus_if.err_len !== 1'b0) begin n_err++; $display("FAIL rmid_ctrl: out_valid=%b in_ready=%b err=%b want 0/1/0", bus_if.out_valid, bus_if.in_ready, bus_if.err_len); end
        bus_if.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < NA; j++) begin
            exp_bus[j*BS +: BS] = 8'(8'hA0 + j);
            push(8'(8'hA0 + j), j == NA - 1);
        end
        n_cmp++; if (bus_if.out_bus !== exp_bus) begin n_err++; $display("FAIL rmid_repack: got %h want %h", bus_if.out_bus, exp_bus); end
        n_cmp++; if (bus_if.out_channel !== 4'd0) begin n_err++; $display("FAIL rmid_repack_channel: got %0d want 0", bus_if.out_channel); end
        release_hold();
    endtask

    initial begin
        test_reset();
        test_full_channel();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_channel_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
